// File: rtl/boot_shadow_ctrl.sv
// Boot shadow controller: holds the CPU in reset, copies the boot ROM image
// into shadow RAM at the top of the word address space, reads it back to
// verify it, and releases the CPU only after a clean verify.
module boot_shadow_ctrl #(
  parameter int                ROM_AW    = 5,
  parameter int                DW        = 16,
  parameter int                AW        = 32,
  parameter logic [ROM_AW-1:0] ROM_FIRST = 5'h0E,
  parameter logic [ROM_AW-1:0] ROM_LAST  = 5'h1D,
  parameter logic [AW-1:0]     DST_BASE  = 32'hFFFF_FFE0,
  parameter int                RST_HOLD  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DW-1:0]     rom_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ready,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Hold counter only needs to reach RST_HOLD-1.
  localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [2:0] {
    S_COPY_RD,
    S_COPY_WR,
    S_VFY,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROM_AW-1:0] r_idx;
  logic [DW-1:0]     r_wdata;
  logic [CW-1:0]     r_hold;
  logic              w_last;
  logic              w_match;

  // The end test precedes any increment, so ROM_LAST may be the all-ones index.
  assign w_last    = (r_idx == ROM_LAST);
  assign w_match   = (mem_rdata == rom_data);
  assign rom_addr  = r_idx;
  assign mem_addr  = DST_BASE + AW'(r_idx);
  assign mem_wdata = r_wdata;

  // State register; reset drops any in-flight request immediately.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= S_COPY_RD;
    else       r_state <= w_state_nxt;
  end

  // Datapath: ROM index, latched write data and post-verify hold counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx   <= ROM_FIRST;
      r_wdata <= '0;
      r_hold  <= '0;
    end else begin
      unique case (r_state)
        S_COPY_RD: r_wdata <= rom_data;
        S_COPY_WR: begin
          if (mem_ready) r_idx <= w_last ? ROM_FIRST : r_idx + ROM_AW'(1);
        end
        S_VFY: begin
          if (mem_ready && w_match) begin
            if (w_last) r_hold <= CW'(RST_HOLD - 1);
            else        r_idx  <= r_idx + ROM_AW'(1);
          end
        end
        S_HOLD: begin
          if (r_hold != '0) r_hold <= r_hold - CW'(1);
        end
        S_RUN, S_ERROR: begin
          if (start) r_idx <= ROM_FIRST;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // signal unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      S_COPY_RD: w_state_nxt = S_COPY_WR;
      S_COPY_WR: begin
        if (mem_ready) w_state_nxt = w_last ? S_VFY : S_COPY_RD;
      end
      S_VFY: begin
        if (mem_ready) begin
          if (!w_match)   w_state_nxt = S_ERROR;
          else if (w_last) w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_hold == '0) w_state_nxt = S_RUN;
      end
      S_RUN, S_ERROR: begin
        if (start) w_state_nxt = S_COPY_RD;
      end
      default: w_state_nxt = S_COPY_RD;
    endcase
  end

  // Output decode purely from the registered state, so outputs never glitch on inputs.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    unique case (r_state)
      S_COPY_RD: busy = 1'b1;
      S_COPY_WR: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_VFY: begin
        busy    = 1'b1;
        mem_req = 1'b1;
      end
      S_HOLD: ;
      S_RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
      end
      S_ERROR: error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_boot_shadow_ctrl.sv
// Directed bench for boot_shadow_ctrl: ROM and RAM models, a transfer log
// monitor, and a linear sequence of scenarios checked with immediate assertions.
module tb_boot_shadow_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        cpu_reset, busy, done, error;

  int n_chk  = 0;
  int n_fail = 0;

  logic corrupt  = 1'b0;
  logic stall_en = 1'b0;

  always #5 clk = ~clk;

  boot_shadow_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // Expected image for ROM words 0x0E..0x1D.
  logic [15:0] exp_data [0:15] = '{
    16'h00A2, 16'hFFFF, 16'h009A, 16'h0018, 16'h00AD, 16'hFFF9, 16'hFFFE, 16'h0049,
    16'h000F, 16'h008D, 16'h0000, 16'hFFFD, 16'h0090, 16'hFFF6, 16'hFFF0, 16'hFFFF
  };

  logic [15:0] rom [0:31];
  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 16'hDEAD;
    for (int i = 0; i < 16; i++) rom[i + 14] = exp_data[i];
  end
  assign rom_data = rom[rom_addr];

  // RAM model, optionally corrupting reads of FFFF_FFF3.
  logic [15:0] ram [0:31];
  always @(posedge clk)
    if (mem_req && mem_we && mem_ready) ram[mem_addr[4:0]] <= mem_wdata;
  assign mem_rdata = (corrupt && mem_addr == 32'hFFFF_FFF3) ? 16'h1234 : ram[mem_addr[4:0]];

  // Backpressure: 3 wait cycles on the write to FFF2 and the read of FFF7.
  logic [1:0] wst_cnt = '0, rst_cnt = '0;
  logic       hit_w, hit_r;
  assign hit_w = stall_en && mem_req && mem_we && mem_addr == 32'hFFFF_FFF2;
  assign hit_r = stall_en && mem_req && !mem_we && mem_addr == 32'hFFFF_FFF7;
  assign mem_ready = !((hit_w && wst_cnt != 2'd3) || (hit_r && rst_cnt != 2'd3));
  always @(posedge clk) begin
    if (reset) begin
      wst_cnt <= '0;
      rst_cnt <= '0;
    end else begin
      if (hit_w && wst_cnt != 2'd3) wst_cnt <= wst_cnt + 2'd1;
      if (hit_r && rst_cnt != 2'd3) rst_cnt <= rst_cnt + 2'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: logs completed transfers, counts stall/error cycles, and checks
  // that a stalled request is held stable into the next cycle.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [15:0] data;
  } xfer_t;
  xfer_t       xlog[$];
  int          stall_cnt = 0;
  int          err_cnt   = 0;
  logic        hold_v    = 1'b0;
  logic        hold_we;
  logic [31:0] hold_addr;
  logic [15:0] hold_data;
  always @(negedge clk) begin
    if (hold_v && !reset) begin
      check("bp_req",   {63'd0, mem_req}, 64'd1);
      check("bp_we",    {63'd0, mem_we},  {63'd0, hold_we});
      check("bp_addr",  {32'd0, mem_addr}, {32'd0, hold_addr});
      check("bp_wdata", {48'd0, mem_wdata}, {48'd0, hold_data});
    end
    hold_v    = mem_req && !mem_ready && !reset;
    hold_we   = mem_we;
    hold_addr = mem_addr;
    hold_data = mem_wdata;
    if (mem_req && !mem_ready) stall_cnt++;
    if (mem_req && mem_ready && !reset) xlog.push_back('{mem_we, mem_addr, mem_wdata});
    if (error) err_cnt++;
  end

  // Bench actions happen just after the falling edge, after the monitor.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("rst_busy",      {63'd0, busy},      64'd1);
    check("rst_done",      {63'd0, done},      64'd0);
    check("rst_error",     {63'd0, error},     64'd0);
    check("rst_mem_req",   {63'd0, mem_req},   64'd0);
    check("rst_mem_we",    {63'd0, mem_we},    64'd0);
    check("rst_mem_wdata", {48'd0, mem_wdata}, 64'd0);
  endtask

  // Steps until done (bounded); optionally pulses start once during COPY_WR.
  task automatic wait_done(input int budget, input bit pulse_wr, output int n);
    bit pulsed = 1'b0;
    n = 0;
    while (!done && n < budget) begin
      if (start) start = 1'b0;
      step();
      n++;
      if (pulse_wr && !pulsed && mem_req && mem_we && n > 4) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
    end
    start = 1'b0;
    check("done_reached", {63'd0, done}, 64'd1);
  endtask

  task automatic verify_log(input int base, input int nwr, input int nrd);
    check("log_size", 64'(xlog.size()), 64'(base + nwr + nrd));
    for (int i = 0; i < nwr + nrd && base + i < xlog.size(); i++) begin
      if (i < nwr) begin
        check("wr_we",   {63'd0, xlog[base+i].we}, 64'd1);
        check("wr_addr", {32'd0, xlog[base+i].addr}, 64'hFFFF_FFEE + 64'(i));
        check("wr_data", {48'd0, xlog[base+i].data}, {48'd0, exp_data[i]});
      end else begin
        check("rd_we",   {63'd0, xlog[base+i].we}, 64'd0);
        check("rd_addr", {32'd0, xlog[base+i].addr}, 64'hFFFF_FFEE + 64'(i - nwr));
      end
    end
  endtask

  initial begin
    int n, base, e0, s0;

    // Default image, zero wait states.
    do_reset();
    base = xlog.size();
    e0   = err_cnt;
    check_reset_vals();
    wait_done(200, 1'b0, n);
    check("release_cycle", 64'(n), 64'd52);
    check("run_cpu_reset", {63'd0, cpu_reset}, 64'd0);
    check("run_busy",      {63'd0, busy},      64'd0);
    verify_log(base, 16, 16);
    check("no_error", 64'(err_cnt - e0), 64'd0);

    // Start in RUN, with an ignored start pulse during COPY_WR of the re-run.
    base  = xlog.size();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("restart_busy",      {63'd0, busy},      64'd1);
    check("restart_done",      {63'd0, done},      64'd0);
    wait_done(200, 1'b1, n);
    check("restart_release", 64'(n), 64'd52);
    verify_log(base, 16, 16);

    // Backpressure: 3 stalls on write FFF2 and on read FFF7.
    stall_en = 1'b1;
    do_reset();
    base = xlog.size();
    s0   = stall_cnt;
    wait_done(300, 1'b0, n);
    check("bp_release", 64'(n), 64'd58);
    check("bp_stalls",  64'(stall_cnt - s0), 64'd6);
    verify_log(base, 16, 16);
    stall_en = 1'b0;

    // Verify mismatch on FFF3.
    corrupt = 1'b1;
    do_reset();
    base = xlog.size();
    n = 0;
    while (!error && n < 200) begin
      step();
      n++;
    end
    check("err_cycle",     64'(n), 64'd38);
    check("err_error",     {63'd0, error},     64'd1);
    check("err_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    check("err_done",      {63'd0, done},      64'd0);
    check("err_mem_req",   {63'd0, mem_req},   64'd0);
    check("err_busy",      {63'd0, busy},      64'd0);
    verify_log(base, 16, 6);
    repeat (20) step();
    check("err_sticky",    {63'd0, error},   64'd1);
    check("err_idle_req",  {63'd0, mem_req}, 64'd0);
    check("err_no_xfer",   64'(xlog.size()), 64'(base + 22));

    // Start in ERROR with a good RAM.
    corrupt = 1'b0;
    base    = xlog.size();
    start   = 1'b1;
    step();
    start = 1'b0;
    check("err_clr_error",     {63'd0, error},     64'd0);
    check("err_clr_busy",      {63'd0, busy},      64'd1);
    check("err_clr_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    wait_done(200, 1'b0, n);
    check("err_clr_release", 64'(n), 64'd52);
    check("err_clr_noerr",   {63'd0, error}, 64'd0);
    verify_log(base, 16, 16);

    // Reset after the 5th write of a run.
    do_reset();
    base = xlog.size();
    n = 0;
    while (xlog.size() < base + 5 && n < 100) begin
      step();
      n++;
    end
    check("five_writes", 64'(xlog.size()), 64'(base + 5));
    step();
    do_reset();
    base = xlog.size();
    check_reset_vals();
    wait_done(200, 1'b0, n);
    check("midrst_release", 64'(n), 64'd52);
    verify_log(base, 16, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/boot_shadow_ctrl.md
# boot_shadow_ctrl

Boot sequencer for the 65Org16 system. It holds the CPU in reset, copies the tiny boot ROM image into shadow RAM at the top of the 32-bit word address space, and reads the copy back to verify it. Only after a clean verify does it release the CPU. It sits between the combinational boot ROM, the system memory port, and the CPU `reset` input. Loading the image from RAM lets the ROM be removed from the run-time decode path.

## Interface

Parameters:
- `ROM_AW`, 5: boot ROM address width.
- `DW`, 16: data word width.
- `AW`, 32: memory address width.
- `ROM_FIRST`, 5'h0E: first ROM word copied. ROM words below this are don't-care and are never read.
- `ROM_LAST`, 5'h1D: last ROM word copied. Required: `ROM_FIRST <= ROM_LAST`.
- `DST_BASE`, 32'hFFFF_FFE0: RAM word address of ROM index 0.
- `RST_HOLD`, 4: cycles `cpu_reset` stays high after a successful verify.

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock. The block has one clock domain.
- `reset`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: re-run request. Honoured only in RUN or ERROR.
- `rom_addr`, out, ROM_AW: index into the boot ROM.
- `rom_data`, in, DW: boot ROM word. It is combinational from `rom_addr`.
- `mem_req`, out, 1: memory request.
- `mem_we`, out, 1: 1 = write, 0 = read. Valid while `mem_req` is high.
- `mem_addr`, out, AW: memory word address.
- `mem_wdata`, out, DW: write data.
- `mem_rdata`, in, DW: read data. Valid in the cycle `mem_req && !mem_we && mem_ready`.
- `mem_ready`, in, 1: transfer completes in any cycle where `mem_req && mem_ready`.
- `cpu_reset`, out, 1: reset to the CPU.
- `busy`, out, 1: a copy or verify is in progress.
- `done`, out, 1: the image is verified and the CPU is released.
- `error`, out, 1: verify mismatch. Sticky.

## Operation

- Index register `idx` (ROM_AW bits) drives `rom_addr`.
- `mem_addr` = `DST_BASE` + zero-extended `idx`, computed modulo 2^AW.
- Word count is `ROM_LAST - ROM_FIRST + 1`, which is 16 by default.
- States and transitions:
  - COPY_RD: latch `rom_data` into the `mem_wdata` register, then go to COPY_WR.
  - COPY_WR: `mem_req=1`, `mem_we=1`.
    - On `mem_ready`, if `idx==ROM_LAST`: set `idx=ROM_FIRST` and go to VFY.
    - Otherwise: `idx++` and go to COPY_RD.
  - VFY: `mem_req=1`, `mem_we=0`. On `mem_ready`, compare `mem_rdata` with `rom_data`.
    - Mismatch: go to ERROR.
    - Match with `idx==ROM_LAST`: load the hold counter with `RST_HOLD-1` and go to HOLD.
    - Match otherwise: `idx++`.
  - HOLD: decrement the counter. At 0, go to RUN.
  - RUN: `cpu_reset=0`, `done=1`. On `start`, set `idx=ROM_FIRST` and go to COPY_RD.
  - ERROR: `error=1`, `cpu_reset=1`. On `start`, clear `error`, set `idx=ROM_FIRST`, and go to COPY_RD.
- `start` is ignored in COPY_RD, COPY_WR, VFY and HOLD.
- `busy` is high in COPY_RD, COPY_WR and VFY.
- `cpu_reset` is high in every state except RUN.
- `idx` never wraps. The end test happens before the increment, so `ROM_LAST` may equal the all-ones index.
- `mem_req`, `mem_we`, `busy`, `done`, `cpu_reset` and `error` are decoded from the registered state. They are glitch-free with respect to inputs.

## Timing

- Reset values:
  - state COPY_RD, `idx=ROM_FIRST`
  - `cpu_reset=1`, `busy=1`, `done=0`, `error=0`
  - `mem_req=0`, `mem_we=0`, `mem_wdata=0`
- Reset asserted in any state, including mid-transfer, restarts on the next cycle with the values above. The in-flight request is dropped.
- Backpressure: while `mem_req && !mem_ready`, the block holds `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stable. Exactly one write and one read occur per word, in ascending address order.
- Zero-wait schedule (`mem_ready` tied to 1), with cycle 0 = first cycle after reset is released:
  - Copy occupies cycles 0–31: two cycles per word.
  - Verify occupies cycles 32–47.
  - HOLD occupies cycles 48–51.
  - `cpu_reset` falls and `done` rises in cycle 52.
- The ERROR decision is made in the cycle the mismatching read completes. ERROR state is visible the following cycle, and `mem_req` drops then.
- `start` accepted in RUN raises `cpu_reset` and `busy` and clears `done` in the next cycle.

## Test plan

- **Default image, `mem_ready=1`:** writes go to FFFF_FFEE..FFFF_FFFD with data 00A2, FFFF, 009A, 0018, 00AD, FFF9, FFFE, 0049, 000F, 008D, 0000, FFFD, 0090, FFF6, FFF0, FFFF. `cpu_reset` falls and `done` rises at cycle 52. `error` stays 0.
- **Backpressure:** hold `mem_ready=0` for 3 cycles on the write to FFFF_FFF2 and on the read of FFFF_FFF7. Address, data and `mem_we` stay stable. No duplicate transfers occur. Release is delayed by exactly 6 cycles, to cycle 58.
- **Verify mismatch:** the RAM model returns 1234 for FFFF_FFF3. The block enters ERROR: `error=1`, `cpu_reset=1`, `done=0`, and `mem_req=0` the following cycle. The state stays there indefinitely with `start` low.
- **Start handling:**
  - `start` pulsed during COPY_WR is ignored.
  - `start` pulsed in RUN raises `cpu_reset` on the next cycle, and the full copy plus verify repeats.
  - `start` pulsed in ERROR with a good RAM model clears `error` and ends in RUN.
- **Reset mid-copy:** assert `reset` for 1 cycle after the 5th write. The next transfer is a write to FFFF_FFEE with 00A2. The sequence completes 52 cycles after reset is released.
